// File: rtl/mem_resp_stage.sv
// mem_resp_stage: MEM pipeline stage. Tracks outstanding data-SRAM requests,
// pairs the response beat with the load held in MEM, extends it and forwards
// the result to WB and to ID.
// Optional feature: define MEM_LD_BLOCK_EN to have MEM flag a pending load to
// ID (mem_ld_block) and qualify forwarding with ready_go.
// Bus layouts (MSB first):
//   ex_mem_bus : {gr_we, res_from_mem, mem_req, mem_type[2:0], addr_low2[1:0],
//                 dest[4:0], pc[31:0], inst[31:0], alu_result[31:0], side}
//                -> 109 fixed bits + SIDE_W
//   mem_wb_bus : {gr_we, pc, inst, final_result, dest, side} -> 102 + SIDE_W
//   mem_id_bus : {fwd_valid, dest, final_result}             -> 38
module mem_resp_stage #(
    parameter int unsigned SIDE_W  = 81,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_mem_valid,
    output logic                 mem_allowin,
    input  logic [SIDE_W+108:0]  ex_mem_bus,
    output logic                 mem_wb_valid,
    input  logic                 wb_allowin,
    output logic [SIDE_W+101:0]  mem_wb_bus,
    input  logic                 data_sram_req_fire,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    output logic                 mem_req_allow,
    input  logic                 flush,
    output logic [37:0]          mem_id_bus,
    output logic                 mem_ld_block
);

    localparam int unsigned CNT_W = 4;

    logic                 mem_valid_q, mem_valid_d;
    logic [SIDE_W+108:0]  bus_q, bus_d;
    logic                 resp_got_q, resp_got_d;
    logic [31:0]          resp_buf_q, resp_buf_d;
    logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]     cancel_cnt_q, cancel_cnt_d;

    logic                 gr_we;
    logic                 res_from_mem;
    logic                 mem_req;
    logic [2:0]           mem_type;
    logic [1:0]           addr_low2;
    logic [4:0]           dest;
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic [31:0]          alu_result;
    logic [SIDE_W-1:0]    side;

    logic                 data_ok_live_c;
    logic                 ready_go_c;
    logic                 leave_c;
    logic                 fwd_valid_c;
    logic [31:0]          ld_data_c;
    logic [15:0]          ld_half_c;
    logic [7:0]           ld_byte_c;
    logic [31:0]          ld_ext_c;
    logic [31:0]          final_result_c;

    // Field decode of the held instruction
    assign {gr_we, res_from_mem, mem_req, mem_type, addr_low2, dest,
            pc, inst, alu_result, side} = bus_q;

    // Handshake: a beat only counts for MEM once all killed responses are drained
    assign data_ok_live_c = data_sram_data_ok & (cancel_cnt_q == '0);
    assign ready_go_c     = ~mem_req | resp_got_q | data_ok_live_c;
    assign mem_allowin    = ~mem_valid_q | (ready_go_c & wb_allowin);
    assign mem_wb_valid   = mem_valid_q & ready_go_c;
    assign leave_c        = mem_valid_q & ready_go_c & wb_allowin;
    assign mem_req_allow  = out_cnt_q < CNT_W'(MAX_OUT);

    // Load lane selection and extension
    always_comb begin
        ld_data_c = resp_got_q ? resp_buf_q : data_sram_rdata;
        ld_half_c = addr_low2[1] ? ld_data_c[31:16] : ld_data_c[15:0];
        ld_byte_c = 8'(ld_data_c >> {addr_low2, 3'b000});
        ld_ext_c  = '0;
        case (mem_type)
            3'b000:  ld_ext_c = ld_data_c;
            3'b001:  ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
            3'b010:  ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            3'b101:  ld_ext_c = {16'h0000, ld_half_c};
            3'b110:  ld_ext_c = {24'h000000, ld_byte_c};
            default: ld_ext_c = '0;
        endcase
        final_result_c = res_from_mem ? ld_ext_c : alu_result;
    end

`ifdef MEM_LD_BLOCK_EN
    assign fwd_valid_c  = mem_valid_q & gr_we & ready_go_c;
    assign mem_ld_block = mem_valid_q & mem_req & res_from_mem & ~ready_go_c;
`else
    assign fwd_valid_c  = mem_valid_q & gr_we;
    assign mem_ld_block = 1'b0;
`endif

    assign mem_wb_bus = {gr_we, pc, inst, final_result_c, dest, side};
    assign mem_id_bus = {fwd_valid_c, dest, final_result_c};

    // Next-state: stage occupancy, response buffer and request counters
    always_comb begin
        mem_valid_d  = mem_valid_q;
        bus_d        = bus_q;
        resp_got_d   = resp_got_q;
        resp_buf_d   = resp_buf_q;
        out_cnt_d    = out_cnt_q;
        cancel_cnt_d = cancel_cnt_q;

        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (mem_allowin) begin
            mem_valid_d = ex_mem_valid;
        end
        if (ex_mem_valid & mem_allowin & ~flush) begin
            bus_d = ex_mem_bus;
        end

        // Hold an early beat until WB takes the instruction
        if (flush | leave_c) begin
            resp_got_d = 1'b0;
        end else if (data_ok_live_c & mem_valid_q & mem_req & ~resp_got_q) begin
            resp_got_d = 1'b1;
            resp_buf_d = data_sram_rdata;
        end

        if (data_sram_req_fire & ~data_sram_data_ok) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (~data_sram_req_fire & data_sram_data_ok) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
        end

        // A flush kills every request still in flight, including this cycle's
        if (flush) begin
            cancel_cnt_d = out_cnt_d;
        end else if (data_sram_data_ok & (cancel_cnt_q != '0)) begin
            cancel_cnt_d = cancel_cnt_q - CNT_W'(1);
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q  <= 1'b0;
            resp_got_q   <= 1'b0;
            out_cnt_q    <= '0;
            cancel_cnt_q <= '0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            resp_got_q   <= resp_got_d;
            out_cnt_q    <= out_cnt_d;
            cancel_cnt_q <= cancel_cnt_d;
        end
    end

    // Payload registers, qualified by the valid/flag registers above
    always_ff @(posedge clk) begin
        bus_q      <= bus_d;
        resp_buf_q <= resp_buf_d;
    end

endmodule
